decode_issue_stage: RTL and testbench



---
 rtl/decode_issue_stage.sv | 237 +++++++++++++++++++++++
 tb/tb_decode_issue_stage.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_issue_stage.sv
// Decode/issue stage: a per-register scoreboard plus a writeback-slot reservation shift register handle MUL/ALU hazards.
// Optional stall performance counters are enabled with the DECODE_PERF_CNT_EN macro.
module decode_issue_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int REGISTER_WIDTH = 5,
    parameter int MUL_LATENCY    = 5,
    parameter int ALU_LATENCY    = 1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      valid_i,
    input  logic                      flush_i,
    input  logic                      mem_stall_i,
    input  logic [31:0]               instruction_i,
    input  logic [ADDR_WIDTH-1:0]     pc_i,
    input  logic [DATA_WIDTH-1:0]     rs1_data_i,
    input  logic [DATA_WIDTH-1:0]     rs2_data_i,
    input  logic                      wb_reg_wr_en_i,
    input  logic [REGISTER_WIDTH-1:0] wb_wr_reg_i,
    input  logic [DATA_WIDTH-1:0]     wb_data_i,
    input  logic [DATA_WIDTH-1:0]     mul_last_result_i,
    output logic [REGISTER_WIDTH-1:0] rs1_o,
    output logic [REGISTER_WIDTH-1:0] rs2_o,
    output logic                      stall_o,
    output logic                      alu_valid_o,
    output logic                      mul_valid_o,
    output logic [ADDR_WIDTH-1:0]     alu_pc_o,
    output logic [DATA_WIDTH-1:0]     op_a_o,
    output logic [DATA_WIDTH-1:0]     op_b_o,
    output logic [DATA_WIDTH-1:0]     imm_o,
    output logic [REGISTER_WIDTH-1:0] rd_o,
    output logic [31:0]               instruction_o,
    output logic [31:0]               stall_raw_cnt_o,
    output logic [31:0]               stall_wb_cnt_o
);

    localparam int NUM_REGS = 2 ** REGISTER_WIDTH;
    localparam int CW       = $clog2(MUL_LATENCY + 1);

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    logic [6:0]                opcode_s;
    logic [2:0]                funct3_s;
    logic [6:0]                funct7_s;
    logic [REGISTER_WIDTH-1:0] rs1_s;
    logic [REGISTER_WIDTH-1:0] rs2_s;
    logic [REGISTER_WIDTH-1:0] rd_s;
    logic [DATA_WIDTH-1:0]     imm_s;
    logic                      is_mul_s;
    logic                      reads_rs1_s;
    logic                      reads_rs2_s;
    logic                      writes_alu_s;
    logic                      raw_s;
    logic                      wb_conflict_s;
    logic                      issue_s;
    logic                      mul_issue_s;
    logic [DATA_WIDTH-1:0]     op_a_s;
    logic [DATA_WIDTH-1:0]     op_b_s;
    logic [MUL_LATENCY:1]      resv_nxt_s;

    logic [CW-1:0]             cnt_r [NUM_REGS];
    logic [MUL_LATENCY:1]      resv_r;
    logic                      alu_valid_r;
    logic                      mul_valid_r;
    logic [ADDR_WIDTH-1:0]     alu_pc_r;
    logic [DATA_WIDTH-1:0]     op_a_r;
    logic [DATA_WIDTH-1:0]     op_b_r;
    logic [DATA_WIDTH-1:0]     imm_r;
    logic [REGISTER_WIDTH-1:0] rd_r;
    logic [31:0]               instruction_r;

    // Source selection: last MUL stage beats WB, WB beats the regfile, x0 reads as zero.
    function automatic logic [DATA_WIDTH-1:0] sel_operand(
        input logic [REGISTER_WIDTH-1:0] src,
        input logic [CW-1:0]             cnt,
        input logic [DATA_WIDTH-1:0]     rf_data,
        input logic [DATA_WIDTH-1:0]     mul_data,
        input logic                      wb_en,
        input logic [REGISTER_WIDTH-1:0] wb_reg,
        input logic [DATA_WIDTH-1:0]     wb_data
    );
        logic [DATA_WIDTH-1:0] res;
        if (src == {REGISTER_WIDTH{1'b0}}) begin
            res = {DATA_WIDTH{1'b0}};
        end else if (cnt == CW'(1)) begin
            res = mul_data;
        end else if (wb_en && (wb_reg == src)) begin
            res = wb_data;
        end else begin
            res = rf_data;
        end
        return res;
    endfunction

    // Instruction field decode and immediate generation.
    always_comb begin
        opcode_s = instruction_i[6:0];
        funct3_s = instruction_i[14:12];
        funct7_s = instruction_i[31:25];
        rs1_s    = REGISTER_WIDTH'(instruction_i[19:15]);
        rs2_s    = REGISTER_WIDTH'(instruction_i[24:20]);
        rd_s     = REGISTER_WIDTH'(instruction_i[11:7]);
        imm_s    = {DATA_WIDTH{1'b0}};
        case (opcode_s)
            OPC_LOAD, OPC_IMM: imm_s = DATA_WIDTH'($signed(instruction_i[31:20]));
            OPC_STORE:  imm_s = DATA_WIDTH'($signed({instruction_i[31:25], instruction_i[11:7]}));
            OPC_BRANCH: imm_s = DATA_WIDTH'($signed({instruction_i[31], instruction_i[7],
                                                     instruction_i[30:25], instruction_i[11:8], 1'b0}));
            OPC_JAL:    imm_s = DATA_WIDTH'($signed({instruction_i[31], instruction_i[19:12],
                                                     instruction_i[20], instruction_i[30:21], 1'b0}));
            OPC_AUIPC:  imm_s = DATA_WIDTH'($signed({instruction_i[31:12], 12'h000}));
            default:    imm_s = {DATA_WIDTH{1'b0}};
        endcase
        is_mul_s     = (opcode_s == OPC_OP) && (funct3_s == 3'b000) && (funct7_s == 7'b0000001);
        reads_rs1_s  = (opcode_s != OPC_JAL) && (opcode_s != OPC_AUIPC);
        reads_rs2_s  = reads_rs1_s && (opcode_s != OPC_LOAD) && (opcode_s != OPC_IMM);
        writes_alu_s = ((opcode_s == OPC_OP) && !is_mul_s) || (opcode_s == OPC_JAL) ||
                       (opcode_s == OPC_IMM) || (opcode_s == OPC_AUIPC);
    end

    // Hazard detection, issue decision and operand bypass.
    always_comb begin
        raw_s = valid_i &&
                ((reads_rs1_s && (rs1_s != {REGISTER_WIDTH{1'b0}}) && (cnt_r[rs1_s] > CW'(1))) ||
                 (reads_rs2_s && (rs2_s != {REGISTER_WIDTH{1'b0}}) && (cnt_r[rs2_s] > CW'(1))));
        wb_conflict_s = valid_i && writes_alu_s && resv_r[ALU_LATENCY + 1];
        issue_s       = valid_i && !flush_i && !raw_s && !wb_conflict_s && !mem_stall_i;
        mul_issue_s   = issue_s && is_mul_s;
        stall_o       = mem_stall_i || (valid_i && !flush_i && (raw_s || wb_conflict_s));
        // A MUL issued now lands in the top reservation slot as the older ones move down.
        resv_nxt_s    = {mul_issue_s, resv_r[MUL_LATENCY:2]};
        op_a_s = sel_operand(rs1_s, cnt_r[rs1_s], rs1_data_i, mul_last_result_i,
                             wb_reg_wr_en_i, wb_wr_reg_i, wb_data_i);
        op_b_s = sel_operand(rs2_s, cnt_r[rs2_s], rs2_data_i, mul_last_result_i,
                             wb_reg_wr_en_i, wb_wr_reg_i, wb_data_i);
    end

    assign rs1_o = rs1_s;
    assign rs2_o = rs2_s;

    // Scoreboard: load on MUL issue (wins over decrement), otherwise count down to zero.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_r[r] <= {CW{1'b0}};
            end
        end else if (!mem_stall_i) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (mul_issue_s && (rd_s != {REGISTER_WIDTH{1'b0}}) && (rd_s == REGISTER_WIDTH'(r))) begin
                    cnt_r[r] <= CW'(MUL_LATENCY);
                end else if (cnt_r[r] != {CW{1'b0}}) begin
                    cnt_r[r] <= cnt_r[r] - CW'(1);
                end
            end
        end
    end

    // Writeback reservation shift register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            resv_r <= {MUL_LATENCY{1'b0}};
        end else if (!mem_stall_i) begin
            resv_r <= resv_nxt_s;
        end
    end

    // Issue registers: load on issue, bubble otherwise, frozen under memory stall.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            alu_valid_r   <= 1'b0;
            mul_valid_r   <= 1'b0;
            alu_pc_r      <= {ADDR_WIDTH{1'b0}};
            op_a_r        <= {DATA_WIDTH{1'b0}};
            op_b_r        <= {DATA_WIDTH{1'b0}};
            imm_r         <= {DATA_WIDTH{1'b0}};
            rd_r          <= {REGISTER_WIDTH{1'b0}};
            instruction_r <= 32'h0000_0000;
        end else if (!mem_stall_i) begin
            if (issue_s) begin
                alu_valid_r   <= !is_mul_s;
                mul_valid_r   <= is_mul_s;
                alu_pc_r      <= pc_i;
                op_a_r        <= op_a_s;
                op_b_r        <= op_b_s;
                imm_r         <= imm_s;
                rd_r          <= rd_s;
                instruction_r <= instruction_i;
            end else begin
                alu_valid_r <= 1'b0;
                mul_valid_r <= 1'b0;
            end
        end
    end

    assign alu_valid_o   = alu_valid_r;
    assign mul_valid_o   = mul_valid_r;
    assign alu_pc_o      = alu_pc_r;
    assign op_a_o        = op_a_r;
    assign op_b_o        = op_b_r;
    assign imm_o         = imm_r;
    assign rd_o          = rd_r;
    assign instruction_o = instruction_r;

`ifdef DECODE_PERF_CNT_EN
    logic [31:0] stall_raw_cnt_r;
    logic [31:0] stall_wb_cnt_r;

    // Stall performance counters, wrapping naturally at 2^32.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_raw_cnt_r <= 32'd0;
            stall_wb_cnt_r  <= 32'd0;
        end else if (!mem_stall_i) begin
            if (raw_s && !issue_s) begin
                stall_raw_cnt_r <= stall_raw_cnt_r + 32'd1;
            end
            if (wb_conflict_s && !raw_s) begin
                stall_wb_cnt_r <= stall_wb_cnt_r + 32'd1;
            end
        end
    end

    assign stall_raw_cnt_o = stall_raw_cnt_r;
    assign stall_wb_cnt_o  = stall_wb_cnt_r;
`else
    assign stall_raw_cnt_o = 32'd0;
    assign stall_wb_cnt_o  = 32'd0;
`endif

endmodule

// File: tb/tb_decode_issue_stage.sv
// Directed bench for decode_issue_stage: a vector table for decode/bypass plus hand sequences for scoreboard timing.
module tb_decode_issue_stage;

`ifdef DECODE_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i, valid_i, flush_i, mem_stall_i, wb_reg_wr_en_i;
    logic [31:0] instruction_i, pc_i, rs1_data_i, rs2_data_i, wb_data_i, mul_last_result_i;
    logic [4:0]  wb_wr_reg_i, rs1_o, rs2_o, rd_o;
    logic        stall_o, alu_valid_o, mul_valid_o;
    logic [31:0] alu_pc_o, op_a_o, op_b_o, imm_o, instruction_o, stall_raw_cnt_o, stall_wb_cnt_o;

    int tests_run = 0;
    int tests_failed = 0;
    int n;

    decode_issue_stage dut (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .flush_i(flush_i),
        .mem_stall_i(mem_stall_i), .instruction_i(instruction_i), .pc_i(pc_i),
        .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .wb_reg_wr_en_i(wb_reg_wr_en_i),
        .wb_wr_reg_i(wb_wr_reg_i), .wb_data_i(wb_data_i), .mul_last_result_i(mul_last_result_i),
        .rs1_o(rs1_o), .rs2_o(rs2_o), .stall_o(stall_o), .alu_valid_o(alu_valid_o),
        .mul_valid_o(mul_valid_o), .alu_pc_o(alu_pc_o), .op_a_o(op_a_o), .op_b_o(op_b_o),
        .imm_o(imm_o), .rd_o(rd_o), .instruction_o(instruction_o),
        .stall_raw_cnt_o(stall_raw_cnt_o), .stall_wb_cnt_o(stall_wb_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] instr;
        logic        valid;
        logic        flush;
        logic [31:0] rs1d;
        logic [31:0] rs2d;
        logic        wb_en;
        logic [4:0]  wb_reg;
        logic [31:0] wb_data;
        logic        exp_stall;
        logic        exp_alu;
        logic        exp_mul;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
        logic [31:0] exp_imm;
        logic [4:0]  exp_rd;
    } vec_t;

    vec_t vecs [12];

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [4:0] rd);
        return {f7, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] opc);
        return {imm, rs1, f3, rd, opc};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic clr_inputs();
        valid_i = 1'b0; flush_i = 1'b0; mem_stall_i = 1'b0; instruction_i = 32'h0000_0013;
        pc_i = 32'h0000_0000; rs1_data_i = 32'h0; rs2_data_i = 32'h0;
        wb_reg_wr_en_i = 1'b0; wb_wr_reg_i = 5'd0; wb_data_i = 32'h0;
        mul_last_result_i = 32'h0000_0030;
    endtask

    task automatic adv();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        clr_inputs();
        rst_i = 1'b1;
        adv();
        rst_i = 1'b0;
    endtask

    // Holds the current inputs until stall_o drops; leaves time at the negedge of the issuing cycle.
    task automatic wait_issue(output int cycles);
        cycles = 0;
        #4;
        while (stall_o && cycles < 20) begin
            adv();
            chk("stall_bubble_valid", {30'd0, alu_valid_o, mul_valid_o}, 32'd0);
            cycles++;
            #4;
        end
    endtask

    initial begin
        clr_inputs();
        rst_i = 1'b1;
        adv();
        adv();
        rst_i = 1'b0;

        chk("reset_alu_valid", {31'd0, alu_valid_o}, 32'd0);
        chk("reset_mul_valid", {31'd0, mul_valid_o}, 32'd0);
        chk("reset_op_a", op_a_o, 32'd0);
        chk("reset_imm", imm_o, 32'd0);
        chk("reset_instr", instruction_o, 32'd0);
        chk("reset_pc", alu_pc_o, 32'd0);

        vecs[0]  = '{enc_i(12'hFFB, 5'd2, 3'b000, 5'd1, 7'b0010011), 1'b1, 1'b0, 32'h100, 32'h200,
                     1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h100, 32'h200, 32'hFFFF_FFFB, 5'd1};
        vecs[1]  = '{enc_r(7'd0, 5'd2, 5'd1, 5'd3), 1'b1, 1'b0, 32'h11, 32'h22,
                     1'b1, 5'd2, 32'hDEAD, 1'b0, 1'b1, 1'b0, 32'h11, 32'hDEAD, 32'h0, 5'd3};
        vecs[2]  = '{enc_r(7'd0, 5'd5, 5'd0, 5'd4), 1'b1, 1'b0, 32'h77, 32'h88,
                     1'b1, 5'd0, 32'h55, 1'b0, 1'b1, 1'b0, 32'h0, 32'h88, 32'h0, 5'd4};
        vecs[3]  = '{{7'h7F, 5'd5, 5'd6, 3'b010, 5'b11000, 7'b0100011}, 1'b1, 1'b0, 32'h600, 32'h500,
                     1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h600, 32'h500, 32'hFFFF_FFF8, 5'd24};
        vecs[4]  = '{{1'b1, 6'b111111, 5'd2, 5'd1, 3'b000, 4'b1110, 1'b1, 7'b1100011}, 1'b1, 1'b0,
                     32'h1, 32'h2, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h1, 32'h2, 32'hFFFF_FFFC, 5'd29};
        vecs[5]  = '{{1'b0, 10'd0, 1'b1, 8'd0, 5'd1, 7'b1101111}, 1'b1, 1'b0, 32'h1234, 32'h5678,
                     1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h5678, 32'h0000_0800, 5'd1};
        vecs[6]  = '{{20'h80001, 5'd2, 7'b0010111}, 1'b1, 1'b0, 32'hAA, 32'hBB,
                     1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h8000_1000, 5'd2};
        vecs[7]  = '{enc_i(12'hFFF, 5'd8, 3'b010, 5'd7, 7'b0000011), 1'b1, 1'b0, 32'h800, 32'h31,
                     1'b1, 5'd8, 32'hCAFE, 1'b0, 1'b1, 1'b0, 32'hCAFE, 32'h31, 32'hFFFF_FFFF, 5'd7};
        vecs[8]  = '{enc_r(7'd0, 5'd2, 5'd1, 5'd9), 1'b0, 1'b0, 32'h1, 32'h2,
                     1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 32'hCAFE, 32'h31, 32'hFFFF_FFFF, 5'd7};
        vecs[9]  = '{enc_i(12'h001, 5'd1, 3'b000, 5'd9, 7'b0010011), 1'b1, 1'b1, 32'h1, 32'h2,
                     1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 32'hCAFE, 32'h31, 32'hFFFF_FFFF, 5'd7};
        vecs[10] = '{enc_r(7'd1, 5'd12, 5'd11, 5'd10), 1'b1, 1'b0, 32'h3, 32'h4,
                     1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h3, 32'h4, 32'h0, 5'd10};
        vecs[11] = '{enc_r(7'd0, 5'd0, 5'd10, 5'd13), 1'b1, 1'b0, 32'h5, 32'h6,
                     1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h3, 32'h4, 32'h0, 5'd10};

        for (int i = 0; i < 12; i++) begin
            instruction_i = vecs[i].instr; valid_i = vecs[i].valid; flush_i = vecs[i].flush;
            rs1_data_i = vecs[i].rs1d; rs2_data_i = vecs[i].rs2d;
            wb_reg_wr_en_i = vecs[i].wb_en; wb_wr_reg_i = vecs[i].wb_reg; wb_data_i = vecs[i].wb_data;
            pc_i = 32'h1000 + 32'(i) * 32'd4;
            #4;
            chk($sformatf("v%0d_stall", i), {31'd0, stall_o}, {31'd0, vecs[i].exp_stall});
            adv();
            chk($sformatf("v%0d_alu_valid", i), {31'd0, alu_valid_o}, {31'd0, vecs[i].exp_alu});
            chk($sformatf("v%0d_mul_valid", i), {31'd0, mul_valid_o}, {31'd0, vecs[i].exp_mul});
            chk($sformatf("v%0d_op_a", i), op_a_o, vecs[i].exp_a);
            chk($sformatf("v%0d_op_b", i), op_b_o, vecs[i].exp_b);
            chk($sformatf("v%0d_imm", i), imm_o, vecs[i].exp_imm);
            chk($sformatf("v%0d_rd", i), {27'd0, rd_o}, {27'd0, vecs[i].exp_rd});
            if (vecs[i].exp_alu || vecs[i].exp_mul) begin
                chk($sformatf("v%0d_pc", i), alu_pc_o, 32'h1000 + 32'(i) * 32'd4);
                chk($sformatf("v%0d_instr", i), instruction_o, vecs[i].instr);
            end
        end

        // Back-to-back dependent ADD after MUL x5: stalls while cnt is 5,4,3,2, then takes the MUL bypass.
        do_reset();
        valid_i = 1'b1; instruction_i = enc_r(7'd1, 5'd2, 5'd1, 5'd5);
        adv();
        chk("seqA_mul_issue", {30'd0, alu_valid_o, mul_valid_o}, 32'd1);
        instruction_i = enc_r(7'd0, 5'd1, 5'd5, 5'd6); rs1_data_i = 32'h999; rs2_data_i = 32'h7;
        wait_issue(n);
        chk("seqA_stall_cycles", n, 32'd4);
        adv();
        chk("seqA_add_issue", {30'd0, alu_valid_o, mul_valid_o}, 32'd2);
        chk("seqA_op_a_bypass", op_a_o, 32'h0000_0030);
        chk("seqA_op_b", op_b_o, 32'h7);
        chk("seqA_perf_raw", stall_raw_cnt_o, PERF ? 32'd4 : 32'd0);

        // MUL to x0 never creates a hazard and x0 operands read as zero; memory stall freezes outputs.
        do_reset();
        valid_i = 1'b1; instruction_i = enc_r(7'd1, 5'd2, 5'd1, 5'd0);
        adv();
        instruction_i = enc_r(7'd0, 5'd0, 5'd0, 5'd3); rs1_data_i = 32'h11; rs2_data_i = 32'h22;
        #4;
        chk("seqB_stall", {31'd0, stall_o}, 32'd0);
        adv();
        chk("seqB_alu_valid", {31'd0, alu_valid_o}, 32'd1);
        chk("seqB_op_a", op_a_o, 32'd0);
        chk("seqB_op_b", op_b_o, 32'd0);
        valid_i = 1'b0; mem_stall_i = 1'b1;
        #4;
        chk("seqB_memstall_stall", {31'd0, stall_o}, 32'd1);
        adv();
        chk("seqB_frozen_valid", {31'd0, alu_valid_o}, 32'd1);
        chk("seqB_frozen_rd", {27'd0, rd_o}, 32'd3);
        mem_stall_i = 1'b0;

        // ALU result would collide with MUL x7 writeback: one-cycle conflict stall.
        do_reset();
        valid_i = 1'b1; instruction_i = enc_r(7'd1, 5'd2, 5'd1, 5'd7);
        adv();
        valid_i = 1'b0;
        adv(); adv(); adv();
        valid_i = 1'b1; instruction_i = enc_i(12'h001, 5'd1, 3'b000, 5'd9, 7'b0010011);
        #4;
        chk("seqC_wb_stall", {31'd0, stall_o}, 32'd1);
        adv();
        chk("seqC_bubble", {30'd0, alu_valid_o, mul_valid_o}, 32'd0);
        #4;
        chk("seqC_no_stall", {31'd0, stall_o}, 32'd0);
        adv();
        chk("seqC_issue", {30'd0, alu_valid_o, mul_valid_o}, 32'd2);
        chk("seqC_imm", imm_o, 32'd1);
        chk("seqC_perf_wb", stall_wb_cnt_o, PERF ? 32'd1 : 32'd0);
        chk("seqC_perf_raw", stall_raw_cnt_o, 32'd0);

        // Flush wins over a hazard; the scoreboard keeps counting down normally.
        do_reset();
        valid_i = 1'b1; instruction_i = enc_r(7'd1, 5'd2, 5'd1, 5'd5);
        adv();
        instruction_i = enc_r(7'd0, 5'd1, 5'd5, 5'd6); flush_i = 1'b1;
        #4;
        chk("seqD_flush_stall", {31'd0, stall_o}, 32'd0);
        adv();
        chk("seqD_flush_bubble", {30'd0, alu_valid_o, mul_valid_o}, 32'd0);
        flush_i = 1'b0;
        wait_issue(n);
        chk("seqD_remaining_stall", n, 32'd3);

        // Memory stall during the countdown freezes cnt at 3 and delays the dependent issue by 4 cycles.
        do_reset();
        valid_i = 1'b1; instruction_i = enc_r(7'd1, 5'd2, 5'd1, 5'd5);
        adv();
        instruction_i = enc_r(7'd0, 5'd1, 5'd5, 5'd6); rs2_data_i = 32'h7;
        adv(); adv();
        mem_stall_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #4;
            chk("seqE_memstall_stall", {31'd0, stall_o}, 32'd1);
            adv();
            chk("seqE_memstall_valids", {30'd0, alu_valid_o, mul_valid_o}, 32'd0);
        end
        mem_stall_i = 1'b0;
        wait_issue(n);
        chk("seqE_post_freeze_stall", n, 32'd2);
        adv();
        chk("seqE_issue", {30'd0, alu_valid_o, mul_valid_o}, 32'd2);
        chk("seqE_op_a_bypass", op_a_o, 32'h0000_0030);
        chk("seqE_perf_raw", stall_raw_cnt_o, PERF ? 32'd4 : 32'd0);

        // Reset mid-countdown forgets the in-flight MUL.
        do_reset();
        valid_i = 1'b1; instruction_i = enc_r(7'd1, 5'd2, 5'd1, 5'd5);
        adv();
        valid_i = 1'b0;
        adv();
        rst_i = 1'b1; valid_i = 1'b1;
        adv();
        chk("seqF_reset_valids", {30'd0, alu_valid_o, mul_valid_o}, 32'd0);
        rst_i = 1'b0;
        instruction_i = enc_r(7'd0, 5'd1, 5'd5, 5'd6); rs1_data_i = 32'hAB; rs2_data_i = 32'hCD;
        #4;
        chk("seqF_no_stall", {31'd0, stall_o}, 32'd0);
        adv();
        chk("seqF_issue", {30'd0, alu_valid_o, mul_valid_o}, 32'd2);
        chk("seqF_op_a_regfile", op_a_o, 32'hAB);
        chk("seqF_op_b_regfile", op_b_o, 32'hCD);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
